stripe_feeder: RTL

STRIPE_FEEDER -- requirements
Module: stripe_feeder

---
 rtl/stripe_feeder_pkg.sv | 26 ++
 rtl/stripe_feeder_seq.sv | 41 ++++
 rtl/stripe_feeder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/stripe_feeder_pkg.sv
// Shared constants and types for the stripe feeder: array geometry, base
// encoding and the controller state encoding.
package stripe_feeder_pkg;

   localparam int N_PE_DEF    = 64;
   localparam int MAX_LEN_DEF = 512;
   localparam int TIMEOUT_DEF = 1023;
   localparam int SCORE_W     = 14;
   localparam int ADDR_W      = 10;

   localparam logic [1:0] BASE_A   = 2'd0;
   localparam logic [1:0] BASE_C   = 2'd1;
   localparam logic [1:0] BASE_G   = 2'd2;
   localparam logic [1:0] BASE_T   = 2'd3;
   localparam logic [1:0] BASE_PAD = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_FEED = 3'd2,
      ST_GAP  = 3'd3,
      ST_WAIT = 3'd4,
      ST_DONE = 3'd5
   } state_t;

endpackage

// File: rtl/stripe_feeder_seq.sv
// Base buffer: one write port and one read port that returns RD_W consecutive
// 2-bit bases starting at the read address (out-of-range bases read as zero).
module seq_buffer
   import stripe_feeder_pkg::*;
#(
   parameter int DEPTH = MAX_LEN_DEF,
   parameter int RD_W  = 1
) (
   input  logic                i_clk,
   input  logic                i_wr_en,
   input  logic [ADDR_W-1:0]   i_wr_addr,
   input  logic [1:0]          i_wr_data,
   input  logic [ADDR_W-1:0]   i_rd_addr,
   output logic [2*RD_W-1:0]   o_rd_data
);
   localparam int IW = $clog2(DEPTH);

   logic [1:0] mem_q [DEPTH];

   // Contents are deliberately not reset so sequences survive an abort.
   always_ff @(posedge i_clk) begin
      if (i_wr_en && ({1'b0, i_wr_addr} < 11'(DEPTH))) begin
         mem_q[i_wr_addr[IW-1:0]] <= i_wr_data;
      end
   end

   always_comb begin
      logic [10:0] idx;
      idx       = 11'd0;
      o_rd_data = '0;
      for (int k = 0; k < RD_W; k++) begin
         idx = {1'b0, i_rd_addr} + 11'(k);
         if (idx < 11'(DEPTH)) begin
            o_rd_data[2*k +: 2] = mem_q[idx[IW-1:0]];
         end else begin
            o_rd_data[2*k +: 2] = BASE_PAD;
         end
      end
   end

endmodule

// File: rtl/stripe_feeder.sv
// Stripe feeder: streams query bases and stripe-wide reference bases into a
// PE array, one stripe at a time, steered by the array's stripe_end feedback.
module stripe_feeder
   import stripe_feeder_pkg::*;
#(
   parameter int N_PE    = N_PE_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic              i_wr_sel,
   input  logic [9:0]        i_wr_addr,
   input  logic [1:0]        i_wr_base,
   input  logic [9:0]        i_len_A,
   input  logic [9:0]        i_len_B,
   input  logic              i_go,
   output logic              o_start,
   output logic [1:0]        o_A,
   output logic [2*N_PE-1:0] o_B,
   input  logic              i_stripe_end,
   input  logic [9:0]        i_start_position,
   output logic [3:0]        o_stripe_idx,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);
   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [10:0]   GAP_LAST = 11'(N_PE - 1);

   state_t            state_q, state_d;
   logic [10:0]       cnt_q, cnt_d;
   logic [CW-1:0]     wcnt_q, wcnt_d;
   logic [9:0]        len_a_q, len_a_d, len_b_q, len_b_d;
   logic [10:0]       a_off_q, a_off_d;
   logic [3:0]        stripe_idx_q, stripe_idx_d;
   logic              pend_q, pend_d;
   logic [9:0]        pend_pos_q, pend_pos_d;
   logic              start_q, start_d;
   logic [1:0]        a_q, a_d;
   logic [2*N_PE-1:0] b_q, b_d;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic              wr_a_s, wr_b_s;
   logic [1:0]        a_rd_s;
   logic [2*N_PE-1:0] b_rd_s, b_stripe_s;
   logic [9:0]        a_addr_s, b_addr_s, se_pos_s;
   logic [15:0]       b_base_s;
   logic [10:0]       a_off_next_s;
   logic              feed_last_s, gap_last_s, wait_last_s;
   logic              se_hit_s, overrun_s, last_stripe_s;

   assign wr_a_s = i_wr_en & ~i_wr_sel;
   assign wr_b_s = i_wr_en & i_wr_sel;

   seq_buffer #(.DEPTH(MAX_LEN), .RD_W(1)) u_buf_a (
      .i_clk     (i_clk),
      .i_wr_en   (wr_a_s),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_base),
      .i_rd_addr (a_addr_s),
      .o_rd_data (a_rd_s)
   );

   seq_buffer #(.DEPTH(MAX_LEN), .RD_W(N_PE)) u_buf_b (
      .i_clk     (i_clk),
      .i_wr_en   (wr_b_s),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_base),
      .i_rd_addr (b_addr_s),
      .o_rd_data (b_rd_s)
   );

   // Pending stripe_end (captured in FEED/GAP) takes precedence over a live one.
   always_comb begin
      b_base_s      = 16'(stripe_idx_q) * 16'(N_PE);
      b_addr_s      = 10'(b_base_s);
      feed_last_s   = (cnt_q == ({1'b0, len_a_q} - a_off_q - 11'd1));
      gap_last_s    = (cnt_q == GAP_LAST);
      wait_last_s   = (wcnt_q == TO_LAST);
      se_hit_s      = pend_q | i_stripe_end;
      se_pos_s      = pend_q ? pend_pos_q : i_start_position;
      a_off_next_s  = a_off_q + {1'b0, se_pos_s};
      overrun_s     = (a_off_next_s >= {1'b0, len_a_q});
      last_stripe_s = ((16'(stripe_idx_q) + 16'd1) * 16'(N_PE)) >= {6'd0, len_b_q};
   end

   // Zero-pad reference bases past the end of B.
   always_comb begin
      b_stripe_s = '0;
      for (int k = 0; k < N_PE; k++) begin
         if ((b_base_s + 16'(k)) < {6'd0, len_b_q}) begin
            b_stripe_s[2*k +: 2] = b_rd_s[2*k +: 2];
         end else begin
            b_stripe_s[2*k +: 2] = BASE_PAD;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wcnt_d       = wcnt_q;
      len_a_d      = len_a_q;
      len_b_d      = len_b_q;
      a_off_d      = a_off_q;
      stripe_idx_d = stripe_idx_q;
      pend_d       = pend_q;
      pend_pos_d   = pend_pos_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d  = 11'd0;
            wcnt_d = '0;
            pend_d = 1'b0;
            if (i_go) begin
               len_a_d      = i_len_A;
               len_b_d      = i_len_B;
               stripe_idx_d = 4'd0;
               a_off_d      = 11'd0;
               if ((i_len_A == 10'd0) || (i_len_B == 10'd0)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_d = ST_FEED;
            cnt_d   = 11'd0;
         end
         ST_FEED, ST_GAP: begin
            if (i_stripe_end) begin
               pend_d     = 1'b1;
               pend_pos_d = i_start_position;
            end else begin
               pend_d = pend_q;
            end
            if ((state_q == ST_FEED) && feed_last_s) begin
               state_d = ST_GAP;
               cnt_d   = 11'd0;
            end else if ((state_q == ST_GAP) && gap_last_s) begin
               state_d = ST_WAIT;
               cnt_d   = 11'd0;
               wcnt_d  = '0;
            end else begin
               cnt_d = cnt_q + 11'd1;
            end
         end
         ST_WAIT: begin
            if (se_hit_s) begin
               pend_d = 1'b0;
               if (overrun_s) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (last_stripe_s) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  a_off_d      = a_off_next_s;
                  stripe_idx_d = (stripe_idx_q == 4'd15) ? stripe_idx_q : stripe_idx_q + 4'd1;
                  state_d      = ST_LOAD;
               end
            end else if (wait_last_s) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wcnt_d = wcnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from next-state values so they align with state_q.
   always_comb begin
      a_addr_s = 10'(a_off_q + cnt_d);
      start_d  = (state_d == ST_FEED);
      a_d      = start_d ? a_rd_s : BASE_PAD;
      b_d      = (state_q == ST_LOAD) ? b_stripe_s : b_q;
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 11'd0;
         wcnt_q       <= '0;
         len_a_q      <= 10'd0;
         len_b_q      <= 10'd0;
         a_off_q      <= 11'd0;
         stripe_idx_q <= 4'd0;
         pend_q       <= 1'b0;
         pend_pos_q   <= 10'd0;
         start_q      <= 1'b0;
         a_q          <= 2'd0;
         b_q          <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wcnt_q       <= wcnt_d;
         len_a_q      <= len_a_d;
         len_b_q      <= len_b_d;
         a_off_q      <= a_off_d;
         stripe_idx_q <= stripe_idx_d;
         pend_q       <= pend_d;
         pend_pos_q   <= pend_pos_d;
         start_q      <= start_d;
         a_q          <= a_d;
         b_q          <= b_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign o_start      = start_q;
   assign o_A          = a_q;
   assign o_B          = b_q;
   assign o_stripe_idx = stripe_idx_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_err        = err_q;

endmodule
